// File: rtl/gemm_batch_seq_pkg.sv
// Shared types and helpers for the GEMM batch sequencer.
package gemm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

  // Address width for a depth, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/gemm_batch_seq_if.sv
// Source, parameter-write, core handshake and destination signals of the batch sequencer.
interface gemm_batch_seq_if #(
  parameter int unsigned SRC_LEN   = 32,
  parameter int unsigned DST_LEN   = 16,
  parameter int unsigned PRM_BANKS = 4,
  parameter int unsigned PRM_DEPTH = 8
);
  import gemm_seq_pkg::*;

  localparam int unsigned SRC_AW = clog2_min1(SRC_LEN);
  localparam int unsigned DST_AW = clog2_min1(DST_LEN);
  localparam int unsigned PRM_AW = clog2_min1(PRM_DEPTH);

  logic                 src_valid;
  logic                 src_ready;
  logic                 src_v;
  logic [SRC_AW-1:0]    src_a;
  logic [PRM_BANKS-1:0] prm_v;
  logic [PRM_AW-1:0]    prm_a;
  logic                 s_init;
  logic                 s_fin;
  logic                 dst_v;
  logic [DST_AW-1:0]    dst_a;
  logic                 dst_valid;
  logic                 dst_last;
  logic                 dst_ready;

  modport master (
    input  src_valid, s_fin, dst_ready,
    output src_ready, src_v, src_a, prm_v, prm_a, s_init,
           dst_v, dst_a, dst_valid, dst_last
  );

  modport slave (
    output src_valid, s_fin, dst_ready,
    input  src_ready, src_v, src_a, prm_v, prm_a, s_init,
           dst_v, dst_a, dst_valid, dst_last
  );

endinterface

// File: rtl/gemm_batch_seq_cnt.sv
// Wrapping address counter with synchronous clear, enable and terminal-count flag.
module gemm_seq_cnt #(
  parameter int unsigned MAX = 8,
  parameter int unsigned W   = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last_c
);

  assign last_c = (cnt == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (clr)     cnt <= '0;
    else if (en) cnt <= last_c ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/gemm_batch_seq.sv
// GEMM batch sequencer: load, core start/finish, result drain, parameter writes.
// Build option GEMM_BATCH_SEQ_OVERLAP_EN lets the next batch load during DRAIN.
module gemm_batch_seq
  import gemm_seq_pkg::*;
#(
  parameter int unsigned SRC_LEN   = 32,
  parameter int unsigned DST_LEN   = 16,
  parameter int unsigned PRM_BANKS = 4,
  parameter int unsigned PRM_DEPTH = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                matw,
  gemm_batch_seq_if.master    bus,
  output logic                busy,
  output logic [CNT_W-1:0]    batch_cnt
);

  localparam int unsigned SRC_AW  = clog2_min1(SRC_LEN);
  localparam int unsigned DST_AW  = clog2_min1(DST_LEN);
  localparam int unsigned PRM_AW  = clog2_min1(PRM_DEPTH);
  localparam int unsigned BANK_AW = clog2_min1(PRM_BANKS);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_LOAD  = 2'(LOAD);
  localparam logic [1:0] S_WAIT  = 2'(WAIT);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);

`ifdef GEMM_BATCH_SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic [1:0]         state, state_nx;
  logic               s_init_q, s_init_nx;
  logic               draw_pending, draw_nx;
  logic               pend, pend_nx;
  logic               dst_valid_q, dst_last_q;
  logic [SRC_AW-1:0]  src_a;
  logic [DST_AW-1:0]  dst_a;
  logic [PRM_AW-1:0]  prm_a;
  logic [BANK_AW-1:0] bank;
  logic               src_a_last, dst_a_last, prm_a_last, bank_wrap_unused;

  logic abort, seq_clr, src_rdy_seq, src_v, load_done;
  logic dst_v, drain_done, prm_wr;

  assign abort   = reset | ~run;
  assign seq_clr = abort | matw;

  // Sequencer-side acceptance; held off while a completed batch awaits s_init.
  assign src_rdy_seq = run & ~reset & ~matw &
                       ((state == S_LOAD) | (OVERLAP & (state == S_DRAIN) & ~pend));
  assign src_v      = bus.src_valid & src_rdy_seq;
  assign load_done  = src_v & src_a_last;

  assign dst_v      = bus.dst_ready & draw_pending & run & ~reset & ~matw;
  assign drain_done = dst_valid_q & dst_last_q & bus.dst_ready;

  assign prm_wr     = bus.src_valid & matw & ~reset;

  gemm_seq_cnt #(.MAX(SRC_LEN), .W(SRC_AW)) u_src_cnt (
    .clk(clk), .clr(seq_clr), .en(src_v), .cnt(src_a), .last_c(src_a_last)
  );

  gemm_seq_cnt #(.MAX(DST_LEN), .W(DST_AW)) u_dst_cnt (
    .clk(clk), .clr(seq_clr), .en(dst_v), .cnt(dst_a), .last_c(dst_a_last)
  );

  gemm_seq_cnt #(.MAX(PRM_DEPTH), .W(PRM_AW)) u_prm_cnt (
    .clk(clk), .clr(reset | ~matw), .en(prm_wr), .cnt(prm_a), .last_c(prm_a_last)
  );

  gemm_seq_cnt #(.MAX(PRM_BANKS), .W(BANK_AW)) u_bank_cnt (
    .clk(clk), .clr(reset | ~matw), .en(prm_wr & prm_a_last), .cnt(bank),
    .last_c(bank_wrap_unused)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_nx  = state;
    s_init_nx = 1'b0;
    draw_nx   = draw_pending;
    pend_nx   = pend;
    case (state)
      S_IDLE: begin
        if (run & ~matw) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (load_done) begin
          state_nx  = S_WAIT;
          s_init_nx = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.s_fin) begin
          state_nx = S_DRAIN;
          draw_nx  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (dst_v & dst_a_last) draw_nx = 1'b0;
        if (drain_done) begin
          pend_nx = 1'b0;
          // A batch fully loaded during the drain starts the core right away.
          if (pend | load_done) begin
            state_nx  = S_WAIT;
            s_init_nx = 1'b1;
          end else begin
            state_nx = S_LOAD;
          end
        end else if (load_done) begin
          pend_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (seq_clr) begin
      state_nx  = S_IDLE;
      s_init_nx = 1'b0;
      draw_nx   = 1'b0;
      pend_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      s_init_q     <= 1'b0;
      draw_pending <= 1'b0;
      pend         <= 1'b0;
    end else begin
      state        <= state_nx;
      s_init_q     <= s_init_nx;
      draw_pending <= draw_nx;
      pend         <= pend_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (abort)          batch_cnt <= '0;
    else if (s_init_nx) batch_cnt <= batch_cnt + CNT_W'(1);
  end

  // One-cycle read latency; the whole stage freezes while the sink stalls.
  always_ff @(posedge clk) begin
    if (seq_clr) begin
      dst_valid_q <= 1'b0;
      dst_last_q  <= 1'b0;
    end else if (bus.dst_ready) begin
      dst_valid_q <= dst_v;
      dst_last_q  <= dst_v & dst_a_last;
    end
  end

  assign busy          = (state != S_IDLE);
  assign bus.src_ready = ~reset & (matw | src_rdy_seq);
  assign bus.src_v     = src_v;
  assign bus.src_a     = src_a;
  assign bus.prm_v     = prm_wr ? (PRM_BANKS'(1) << bank) : '0;
  assign bus.prm_a     = prm_a;
  assign bus.s_init    = s_init_q;
  assign bus.dst_v     = dst_v;
  assign bus.dst_a     = dst_a;
  assign bus.dst_valid = dst_valid_q;
  assign bus.dst_last  = dst_last_q;

endmodule

// File: tb/tb_gemm_batch_seq.sv
// Scoreboard bench for gemm_batch_seq: stimulus queues expectations, a negedge monitor checks them.
module tb_gemm_batch_seq;

  localparam int unsigned SRC_LEN   = 32;
  localparam int unsigned DST_LEN   = 16;
  localparam int unsigned PRM_BANKS = 4;
  localparam int unsigned PRM_DEPTH = 8;
  localparam int unsigned CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset, run, matw, busy;
  logic [CNT_W-1:0] batch_cnt;

  gemm_batch_seq_if #(
    .SRC_LEN(SRC_LEN), .DST_LEN(DST_LEN), .PRM_BANKS(PRM_BANKS), .PRM_DEPTH(PRM_DEPTH)
  ) bus ();

  gemm_batch_seq #(
    .SRC_LEN(SRC_LEN), .DST_LEN(DST_LEN), .PRM_BANKS(PRM_BANKS),
    .PRM_DEPTH(PRM_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .matw(matw),
    .bus(bus), .busy(busy), .batch_cnt(batch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  int qsrc[$];
  int qprm[$];
  int qda[$];
  int qhs[$];
  int qi_cyc[$];
  int qi_cnt[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitor
  initial begin
    bit hold;
    bit hold_last;
    hold = 1'b0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (hold) begin
          chk("dst_valid_hold", 32'(bus.dst_valid), 1);
          chk("dst_last_hold", 32'(bus.dst_last), 32'(hold_last));
        end
        if (bus.src_v) begin
          if (qsrc.size() == 0) chk("src_v_unexpected", 32'(bus.src_v), 0);
          else                  chk("src_a", 32'(bus.src_a), qsrc.pop_front());
        end
        if (bus.prm_v != '0) begin
          if (qprm.size() == 0) chk("prm_v_unexpected", 32'(bus.prm_v), 0);
          else                  chk("prm_v_a", 32'({bus.prm_v, bus.prm_a}), qprm.pop_front());
        end
        if (bus.dst_v) begin
          if (qda.size() == 0) chk("dst_v_unexpected", 32'(bus.dst_v), 0);
          else                 chk("dst_a", 32'(bus.dst_a), qda.pop_front());
        end
        if (bus.dst_valid & bus.dst_ready) begin
          if (qhs.size() == 0) chk("dst_hs_unexpected", 32'(bus.dst_valid), 0);
          else                 chk("dst_last", 32'(bus.dst_last), qhs.pop_front());
        end
        if (bus.s_init) begin
          if (qi_cyc.size() == 0) chk("s_init_unexpected", 32'(bus.s_init), 0);
          else begin
            chk("s_init_cycle", cyc, qi_cyc.pop_front());
            chk("batch_cnt_at_init", 32'(batch_cnt), qi_cnt.pop_front());
          end
        end
        hold      = bus.dst_valid & ~bus.dst_ready;
        hold_last = bus.dst_last;
      end
    end
  end

  // Feed n beats starting at address 'first'; imm=1 expects s_init right after the last beat.
  task automatic load(input int n, input int first, input int exp_cnt, input bit imm);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit acc;
      qsrc.push_back(first + i);
      bus.src_valid = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 200) begin
        smp();
        acc = bus.src_ready;
        if (!acc) begin
          tick();
          guard++;
        end
      end
      if (!acc) begin
        n_chk++;
        n_fail++;
        $display("FAIL load_timeout: beat %0d not accepted within 200 cycles", first + i);
        break;
      end
      if (imm && (first + i == int'(SRC_LEN) - 1)) begin
        qi_cyc.push_back(cyc + 1);
        qi_cnt.push_back(exp_cnt);
      end
      tick();
    end
    bus.src_valid = 1'b0;
  endtask

  task automatic push_drain();
    for (int a = 0; a < int'(DST_LEN); a++) begin
      qda.push_back(a);
      qhs.push_back((a == int'(DST_LEN) - 1) ? 1 : 0);
    end
  endtask

  // Run dst_ready (toggling or steady) until the dst_last handshake.
  task automatic drain_wait(input bit toggle, input bit push_init, input int exp_cnt);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      bus.dst_ready = toggle ? ~k[0] : 1'b1;
      smp();
      if (bus.dst_valid & bus.dst_last & bus.dst_ready) begin
        done = 1'b1;
        if (push_init) begin
          qi_cyc.push_back(cyc + 1);
          qi_cnt.push_back(exp_cnt);
        end
      end
      tick();
      k++;
    end
    bus.dst_ready = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: no dst_last handshake within 200 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl[5];
    tbl = '{1, 2, 4, 8, 1};
    reset = 1'b1;
    run = 1'b0;
    matw = 1'b0;
    bus.src_valid = 1'b0;
    bus.s_fin = 1'b0;
    bus.dst_ready = 1'b0;
    repeat (3) tick();

    smp();
    chk("rst_src_ready", 32'(bus.src_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_batch_cnt", 32'(batch_cnt), 0);
    chk("rst_s_init", 32'(bus.s_init), 0);
    chk("rst_dst_valid", 32'(bus.dst_valid), 0);
    chk("rst_dst_last", 32'(bus.dst_last), 0);
    chk("rst_src_a", 32'(bus.src_a), 0);
    chk("rst_dst_a", 32'(bus.dst_a), 0);
    chk("rst_prm_v", 32'(bus.prm_v), 0);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // s_fin while idle is ignored
    bus.s_fin = 1'b1;
    tick();
    bus.s_fin = 1'b0;
    smp();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_src_ready", 32'(bus.src_ready), 0);
    tick();

    // enter LOAD; s_fin there is ignored as well
    run = 1'b1;
    tick();
    tick();
    bus.s_fin = 1'b1;
    tick();
    bus.s_fin = 1'b0;
    smp();
    chk("load_sfin_src_ready", 32'(bus.src_ready), 1);
    chk("load_busy", 32'(busy), 1);
    tick();

    // basic batch
    load(32, 0, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("wait_src_ready", 32'(bus.src_ready), 0);
      chk("wait_busy", 32'(busy), 1);
      tick();
    end
    smp();
    chk("wait_batch_cnt", 32'(batch_cnt), 1);
    tick();

    // drain with dst_ready toggling 1,0
    push_drain();
    bus.s_fin = 1'b1;
    tick();
    bus.s_fin = 1'b0;
    drain_wait(1'b1, 1'b0, 0);
    smp();
    chk("post_drain_src_ready", 32'(bus.src_ready), 1);
    chk("post_drain_dst_valid", 32'(bus.dst_valid), 0);
    tick();

    // abort during beat 10
    load(10, 0, 0, 1'b1);
    bus.src_valid = 1'b1;
    run = 1'b0;
    tick();
    bus.src_valid = 1'b0;
    smp();
    chk("abort_batch_cnt", 32'(batch_cnt), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_src_a", 32'(bus.src_a), 0);
    tick();
    run = 1'b1;
    tick();
    load(32, 0, 1, 1'b1);

    // matw mode: 40 parameter beats
    matw = 1'b1;
    tick();
    smp();
    chk("matw_src_ready", 32'(bus.src_ready), 1);
    chk("matw_busy", 32'(busy), 0);
    chk("matw_batch_cnt", 32'(batch_cnt), 1);
    tick();
    for (int j = 0; j < 40; j++) begin
      qprm.push_back((tbl[j / 8] << 3) | (j % 8));
      bus.src_valid = 1'b1;
      tick();
    end
    bus.src_valid = 1'b0;
    matw = 1'b0;
    smp();
    chk("matw_off_prm_v", 32'(bus.prm_v), 0);
    tick();

`ifdef GEMM_BATCH_SEQ_OVERLAP_EN
    // next batch loads during the drain; s_init follows the dst_last handshake
    run = 1'b0;
    tick();
    smp();
    chk("ov_clear_cnt", 32'(batch_cnt), 0);
    tick();
    run = 1'b1;
    tick();
    load(32, 0, 1, 1'b1);
    push_drain();
    bus.dst_ready = 1'b0;
    bus.s_fin = 1'b1;
    tick();
    bus.s_fin = 1'b0;
    load(32, 0, 2, 1'b0);
    smp();
    chk("ov_pend_src_ready", 32'(bus.src_ready), 0);
    chk("ov_pend_batch_cnt", 32'(batch_cnt), 1);
    tick();
    drain_wait(1'b0, 1'b1, 2);
    smp();
    chk("ov_wait_busy", 32'(busy), 1);
    chk("ov_wait_src_ready", 32'(bus.src_ready), 0);
    tick();
    push_drain();
    bus.s_fin = 1'b1;
    tick();
    bus.s_fin = 1'b0;
    drain_wait(1'b0, 1'b0, 0);
`endif

    repeat (5) tick();
    chk("left_src", qsrc.size(), 0);
    chk("left_prm", qprm.size(), 0);
    chk("left_dst_a", qda.size(), 0);
    chk("left_dst_hs", qhs.size(), 0);
    chk("left_s_init", qi_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_batch_seq.md
Name: gemm_batch_seq

Overview:
- Parametrised successor to the GEMM batch controller.
- Sequences one batch through the core in four steps: source-stream load into the input buffer, core start/finish handshake, result drain onto the destination stream, and parameter-memory writes in matw mode.
- Adds what the previous generation lacked:
  - generic sizes and bank count;
  - real src_ready backpressure while the core is busy;
  - a loaded-batch counter.

Parameters:
- SRC_LEN, 32: source beats per batch; input buffer depth.
- DST_LEN, 16: result words per batch.
- PRM_BANKS, 4: parameter banks; width of prm_v.
- PRM_DEPTH, 8: words per parameter bank.
- CNT_W, 16: width of batch_cnt.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- run  in  1  level; 0 aborts and clears all sequencing state.
- matw  in  1  level; 1 selects parameter-write mode.
- src_valid  in  1  source beat valid.
- src_ready  out  1  source beat accepted when high.
- src_v  out  1  input-buffer write strobe.
- src_a  out  $clog2(SRC_LEN)  input-buffer write address.
- prm_v  out  PRM_BANKS  one-hot parameter-bank write strobe.
- prm_a  out  $clog2(PRM_DEPTH)  parameter write address.
- s_init  out  1  one-cycle core start pulse.
- s_fin  in  1  one-cycle core done pulse.
- dst_v  out  1  result-buffer read strobe.
- dst_a  out  $clog2(DST_LEN)  result-buffer read address.
- dst_valid  out  1  destination beat valid.
- dst_last  out  1  final beat of batch.
- dst_ready  in  1  destination accepts beat.
- busy  out  1  high in any state other than IDLE.
- batch_cnt  out  CNT_W  batches loaded since reset or run fall.

Behaviour:
- Reset state, also forced on any cycle with run=0 (reset or ~run has priority over all other events):
  - all outputs 0; state IDLE; every counter 0.
  - Exception: prm_* is governed only by reset and matw (see matw mode).
- States: IDLE, LOAD, WAIT, DRAIN.
  - IDLE -> LOAD when run=1 and matw=0.
  - LOAD -> WAIT on the cycle the beat at src_a=SRC_LEN-1 is accepted.
  - WAIT -> DRAIN on s_fin.
  - DRAIN -> LOAD on the handshake dst_valid&dst_last&dst_ready.
  - Any state -> IDLE when matw=1. No beats are lost: src_ready is already low in WAIT/DRAIN.
- Source accept, LOAD only:
  - src_ready=1 in LOAD and in matw mode; 0 otherwise.
  - src_v = src_valid & src_ready & ~matw, combinational, same cycle.
  - src_a is 0 at LOAD entry and increments on each accepted beat, wrapping to 0 after SRC_LEN-1.
- s_init is registered: it pulses on the cycle after the last source beat is accepted.
  - batch_cnt increments on that same cycle and wraps modulo 2^CNT_W.
- s_fin outside WAIT is ignored.
- Drain:
  - dst_v = dst_ready & draw_pending, where draw_pending is set on the cycle after s_fin and cleared after the read at DST_LEN-1.
  - dst_a starts at 0 and increments on each dst_v.
  - Read data has 1-cycle latency: dst_valid and dst_last are registered copies of dst_v and (dst_v & dst_a==DST_LEN-1).
  - When dst_ready=0 the whole drain pipeline freezes and dst_valid/dst_last hold.
  - dst_valid never depends combinationally on dst_ready.
- matw mode, independent of run:
  - each src_valid beat asserts prm_v = 1<<bank, combinational;
  - prm_a increments, and bank increments when prm_a wraps from PRM_DEPTH-1;
  - bank wraps to 0 after PRM_BANKS-1;
  - prm_a and bank clear on reset or matw=0;
  - prm_v=0 when src_valid=0 or matw=0.
- Simultaneous events:
  - s_fin in the same cycle as run=0: abort wins.
  - matw rising mid-LOAD: src_a clears; the partial batch is discarded and batch_cnt is unchanged.

Optional Feature:
- Macro: GEMM_BATCH_SEQ_OVERLAP_EN.
- Defined:
  - src_ready is also high in DRAIN, so the next batch loads while the previous one drains.
  - If loading completes before the drain ends, s_init is held off and pulses on the cycle after the dst_last handshake. Then DRAIN -> WAIT directly.
  - Loading stops at SRC_LEN beats: src_ready=0 while s_init is pending.
- Undefined: strict LOAD/WAIT/DRAIN serialisation as above.

Decomposition:
- Package gemm_seq_pkg holds the state enum (IDLE, LOAD, WAIT, DRAIN) and the width helper function clog2_min1, which returns at least 1.
- One sub-module: gemm_seq_cnt, a wrap counter with clear, enable and last flag. It is instantiated for src_a, dst_a, prm_a and the bank counter.

Test Plan:
- Basic batch: run=1, 32 src beats with no gaps -> src_a 0..31; s_init pulses 1 cycle after beat 31; src_ready=0 until s_fin; batch_cnt=1.
- Drain with dst_ready toggling 1,0 -> exactly 16 dst_valid handshakes at dst_a 0..15, dst_last only on the 16th; dst_valid stable while dst_ready=0.
- matw=1 with 40 src_valid beats -> prm_v 0001 for beats 0-7, 0010 for 8-15, 0100 for 16-23, 1000 for 24-31, 0001 again for 32-39; src_v never high.
- Abort: run=0 during beat 10 of LOAD, then run=1 -> src_a restarts at 0; no s_init; batch_cnt=0.
- s_fin in IDLE or LOAD -> ignored; no dst_v.
- OVERLAP_EN: 32 src beats during DRAIN -> second s_init exactly 1 cycle after the first batch's dst_last handshake; batch_cnt=2.
